// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: registered N-way round-robin arbiter feeding a single output register.
// Optional macro LAST_LOCK_EN adds in_last/out_last and locks the grant for multi-beat packets.
module rr_mux_arbiter #(
   parameter int NUM_IN = 4,
   parameter int DATA_W = 8,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_IN-1:0]        in_valid,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   output logic [NUM_IN-1:0]        in_ready,
`ifdef LAST_LOCK_EN
   input  logic [NUM_IN-1:0]        in_last,
   output logic                     out_last,
`endif
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_sel,
   input  logic                     out_ready
);

   localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q,  out_data_d;
   logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
   logic [SEL_W-1:0]    ptr_q,       ptr_d;
   logic                load_en;
   logic [NUM_IN-1:0]   eligible;
   logic                found;
   logic [SEL_W-1:0]    grant;
   logic [SEL_W:0]      idx;
`ifdef LAST_LOCK_EN
   logic                lock_q, lock_d;
   logic                out_last_q, out_last_d;
`endif

   // Handshake: a word transfers on a rising edge where valid and ready are both high;
   // in_valid may drop without a transfer, and out_data/out_sel hold while out_valid && !out_ready.
   assign load_en = !out_valid_q || out_ready;

   // While locked, only the source that owns the open packet (still held in out_sel_q) competes.
   always_comb begin
      eligible = in_valid;
`ifdef LAST_LOCK_EN
      if (lock_q) eligible = in_valid & (NUM_IN'(1) << out_sel_q);
`endif
   end

   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
         if (idx >= NUM_IN_W) idx = idx - NUM_IN_W;
         if (!found && eligible[idx[SEL_W-1:0]]) begin
            found = 1'b1;
            grant = idx[SEL_W-1:0];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (rst_n && load_en && found) in_ready[grant] = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
`ifdef LAST_LOCK_EN
      lock_d      = lock_q;
      out_last_d  = out_last_q;
`endif
      if (load_en) begin
         if (found) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant*DATA_W +: DATA_W];
            out_sel_d   = grant;
            ptr_d       = (grant == SEL_W'(NUM_IN-1)) ? '0 : grant + 1'b1;
`ifdef LAST_LOCK_EN
            lock_d      = !in_last[grant];
            out_last_d  = in_last[grant];
`endif
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
`ifdef LAST_LOCK_EN
         lock_q      <= 1'b0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
`ifdef LAST_LOCK_EN
         lock_q      <= lock_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
`ifdef LAST_LOCK_EN
   assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed literal checks plus randomized traffic against a behavioural model.
// Build with +define+LAST_LOCK_EN to cover the packet-lock variant.
module tb_rr_mux_arbiter;
   localparam int NUM_IN = 4;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_IN-1:0]        in_valid = '0;
   logic [NUM_IN*DATA_W-1:0] in_data = '0;
   logic [NUM_IN-1:0]        in_ready;
   logic [NUM_IN-1:0]        in_last = '0;
   logic                     out_last;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic [SEL_W-1:0]         out_sel;
   logic                     out_ready = 1'b0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
`ifdef LAST_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

`ifndef LAST_LOCK_EN
   assign out_last = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: output register contents, rotating priority start, open-packet owner.
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   int                m_sel;
   int                m_ptr;
   bit                m_lock;
   int                m_lock_src;
   bit                m_last;
   int                m_g;
   logic [NUM_IN-1:0] exp_ready;

   function automatic int m_grant();
      if (m_lock) return in_valid[m_lock_src] ? m_lock_src : -1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_valid[(m_ptr + k) % NUM_IN]) return (m_ptr + k) % NUM_IN;
      end
      return -1;
   endfunction

   always_comb m_g = m_grant();

   always_comb begin
      exp_ready = '0;
      if (rst_n && (!m_valid || out_ready) && m_g >= 0) exp_ready[m_g] = 1'b1;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data <= '0;
         m_sel <= 0;
         m_ptr <= 0;
         m_lock <= 1'b0;
         m_lock_src <= 0;
         m_last <= 1'b0;
      end else if (!m_valid || out_ready) begin
         if (m_g < 0) begin
            m_valid <= 1'b0;
         end else begin
            m_valid <= 1'b1;
            m_data <= in_data[m_g*DATA_W +: DATA_W];
            m_sel <= m_g;
            m_ptr <= (m_g + 1) % NUM_IN;
`ifdef LAST_LOCK_EN
            m_last <= in_last[m_g];
            m_lock <= !in_last[m_g];
            m_lock_src <= m_g;
`endif
         end
      end
   end

   always @(negedge clk) begin
      chk("cmp_in_ready", in_ready, exp_ready);
      chk("cmp_out_valid", out_valid, m_valid);
      chk("cmp_out_data", out_data, m_data);
      chk("cmp_out_sel", out_sel, m_sel);
      chk("cmp_out_last", out_last, m_last);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 4'b1111;
      in_data = 32'h44332211;
      out_ready = 1'b1;
      repeat (3) cyc();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 4'b0001);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("rr_seq_valid", out_valid, 1);
         chk("rr_seq_sel", out_sel, i % 4);
      end

      in_valid = 4'b0100;
      in_data = 32'h00A50000;
      #1;
      chk("single_in_ready", in_ready, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("single_valid", out_valid, 1);
         chk("single_data", out_data, 8'hA5);
         chk("single_sel", out_sel, 2);
      end

      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_out_sel", out_sel, 0);
      rst_n = 1'b1;
      in_valid = 4'b1111;
      in_data = 32'h44332211;
      cyc();
      chk("bp_first_sel", out_sel, 0);
      chk("bp_first_data", out_data, 8'h11);
      out_ready = 1'b0;
      #1;
      chk("bp_in_ready", in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_data", out_data, 8'h11);
         chk("bp_hold_sel", out_sel, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", in_ready, 4'b0010);
      cyc();
      chk("bp_next_sel", out_sel, 1);
      chk("bp_next_data", out_data, 8'h22);

      in_valid = 4'b0100;
      cyc();
      chk("wrap_pre_sel", out_sel, 2);
      in_valid = 4'b1001;
      cyc();
      chk("wrap_sel_a", out_sel, 3);
      cyc();
      chk("wrap_sel_b", out_sel, 0);
      cyc();
      chk("wrap_sel_c", out_sel, 3);

      in_valid = 4'b0000;
      cyc();
      chk("drain_valid", out_valid, 0);
      chk("drain_sel_hold", out_sel, 3);
      chk("drain_data_hold", out_data, 8'h44);

`ifdef LAST_LOCK_EN
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      in_data = 32'h44332211;
      in_valid = 4'b0110;
      in_last = 4'b0000;
      cyc();
      chk("lock_beat1_sel", out_sel, 1);
      chk("lock_beat1_last", out_last, 0);
      cyc();
      chk("lock_beat2_sel", out_sel, 1);
      chk("lock_beat2_last", out_last, 0);
      in_last = 4'b0010;
      cyc();
      chk("lock_beat3_sel", out_sel, 1);
      chk("lock_beat3_last", out_last, 1);
      in_last = 4'b0000;
      cyc();
      chk("lock_next_sel", out_sel, 2);
      chk("lock_next_last", out_last, 0);
      in_valid = 4'b0011;
      cyc();
      chk("lock_stall_valid", out_valid, 0);
`endif

      for (int i = 0; i < 3000; i++) begin
         in_valid = 4'($urandom_range(0, 15));
         in_data = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         in_last = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
         end else begin
            cyc();
         end
      end

      in_valid = '0;
      repeat (2) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
